sdram_req_sched: RTL and testbench

- Request scheduler that sits directly upstream of the Apple II SDRAM controller.
- Arbitrates two byte-wide requesters: CPU (port A, priority) and DMA/disk (port B).
- Drives the controller's addr/we/din/aux inputs once per 14-phase memory slot. The slot is aligned to clkref.
- Captures the controller's raw 16-bit read bus at the data-valid phase and returns the selected byte with a one-cycle ack.

---
 rtl/sdram_req_sched_if.sv | 60 ++++++
 rtl/sdram_req_sched.sv | 213 +++++++++++++++++++++
 tb/tb_sdram_req_sched.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/sdram_req_sched_if.sv
// ----------------------------------------------------------------------------
// sdram_req_sched_if
//   Bundles the two byte-wide requester ports (A = CPU, B = DMA/disk) and the
//   SDRAM controller-facing signals used by sdram_req_sched.
//
//   Requester port x (x = a, b):
//     x_req   level request, held until x_ack
//     x_addr  25-bit byte address
//     x_aux   byte lane select (1 = upper byte of the 16-bit word)
//     x_we    write enable
//     x_din   write data
//     x_dout  read data, valid when x_ack pulses after a read
//     x_ack   one-cycle completion pulse
//   Controller side:
//     mem_addr, mem_we, mem_din, mem_aux  registered request to the controller
//     mem_dout                            raw 16-bit read bus from the controller
//
//   Modports: slave  = scheduler view, master = requesters/controller model.
// ----------------------------------------------------------------------------
interface sdram_req_sched_if;
    logic        a_req;
    logic [24:0] a_addr;
    logic        a_aux;
    logic        a_we;
    logic [7:0]  a_din;
    logic [7:0]  a_dout;
    logic        a_ack;

    logic        b_req;
    logic [24:0] b_addr;
    logic        b_aux;
    logic        b_we;
    logic [7:0]  b_din;
    logic [7:0]  b_dout;
    logic        b_ack;

    logic [24:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_din;
    logic        mem_aux;
    logic [15:0] mem_dout;

    modport slave (
        input  a_req, a_addr, a_aux, a_we, a_din,
        output a_dout, a_ack,
        input  b_req, b_addr, b_aux, b_we, b_din,
        output b_dout, b_ack,
        output mem_addr, mem_we, mem_din, mem_aux,
        input  mem_dout
    );

    modport master (
        output a_req, a_addr, a_aux, a_we, a_din,
        input  a_dout, a_ack,
        output b_req, b_addr, b_aux, b_we, b_din,
        input  b_dout, b_ack,
        input  mem_addr, mem_we, mem_din, mem_aux,
        output mem_dout
    );
endinterface

// File: rtl/sdram_req_sched.sv
// ----------------------------------------------------------------------------
// sdram_req_sched
//   Request scheduler in front of the Apple II SDRAM controller. Tracks the
//   controller's clkref-aligned memory slot, grants one of two requesters per
//   slot, drives the controller inputs and returns the selected read byte
//   with a one-cycle ack.
//
//   Ports:
//     clk        memory clock (same as the controller)
//     init_n     asynchronous active-low reset
//     clkref     slot reference, same signal the controller receives
//     ram_ready  controller initialisation complete
//     bus        sdram_req_sched_if.slave (requester ports A/B + controller)
//
//   Build option:
//     FAIR_ARB_EN  when defined, simultaneous requests alternate between A and
//                  B; when undefined, A has fixed priority.
// ----------------------------------------------------------------------------
module sdram_req_sched #(
    parameter int NUM_PHASES    = 14,
    parameter int LATCH_PHASE   = 13,
    parameter int CAPTURE_PHASE = 5
) (
    input  logic                 clk,
    input  logic                 init_n,
    input  logic                 clkref,
    input  logic                 ram_ready,
    sdram_req_sched_if.slave     bus
);

    localparam int PW = $clog2(NUM_PHASES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY_A,
        ST_BUSY_B
    } state_t;

    typedef enum logic {
        PORT_A,
        PORT_B
    } port_t;

    logic [PW-1:0] phase_q, phase_d;
    logic          synced_q, synced_d;
    state_t        state_q, state_d;

    logic [24:0]   mem_addr_q, mem_addr_d;
    logic          mem_we_q, mem_we_d;
    logic [7:0]    mem_din_q, mem_din_d;
    logic          mem_aux_q, mem_aux_d;

    logic [7:0]    a_dout_q, a_dout_d;
    logic          a_ack_q, a_ack_d;
    logic [7:0]    b_dout_q, b_dout_d;
    logic          b_ack_q, b_ack_d;

`ifdef FAIR_ARB_EN
    port_t         rr_last_q, rr_last_d;
`endif

    logic          at_last;
    logic          at_zero;
    logic          latch_ev;
    logic          win_a;
    logic          win_b;
    logic [7:0]    rd_byte;

    // ------------------------------------------------------------------
    // Phase counter: mirrors the controller's slot counter. The slot ends
    // at NUM_PHASES-1 only when clkref is low and phase 0 leaves only when
    // clkref is high, so a stalled clkref freezes the slot.
    // ------------------------------------------------------------------
    assign at_last = (phase_q == PW'(NUM_PHASES - 1));
    assign at_zero = (phase_q == '0);

    always_comb begin
        phase_d  = phase_q;
        synced_d = synced_q;
        if (at_last) begin
            if (!clkref) begin
                phase_d  = '0;
                synced_d = 1'b1;
            end
        end else if (at_zero) begin
            if (clkref) phase_d = PW'(1);
        end else begin
            phase_d = phase_q + PW'(1);
        end
    end

    // The decision is taken only on the cycle that leaves LATCH_PHASE, so a
    // phase held by a stalled clkref never produces repeated grants.
    assign latch_ev = (phase_q == PW'(LATCH_PHASE)) && (phase_d != phase_q);

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
`ifdef FAIR_ARB_EN
    always_comb begin
        if (bus.a_req && bus.b_req) win_a = (rr_last_q == PORT_B);
        else                        win_a = bus.a_req;
        win_b = bus.b_req && !win_a;
    end
`else
    assign win_a = bus.a_req;
    assign win_b = bus.b_req && !bus.a_req;
`endif

    assign rd_byte = mem_aux_q ? bus.mem_dout[15:8] : bus.mem_dout[7:0];

    // ------------------------------------------------------------------
    // Slot FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a hold/default value before any branch so
        // no path leaves it unassigned, which would infer a latch.
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        mem_we_d   = mem_we_q;
        mem_din_d  = mem_din_q;
        mem_aux_d  = mem_aux_q;
        a_dout_d   = a_dout_q;
        b_dout_d   = b_dout_q;
        a_ack_d    = 1'b0;
        b_ack_d    = 1'b0;
`ifdef FAIR_ARB_EN
        rr_last_d  = rr_last_q;
`endif

        if (latch_ev) begin
            state_d = ST_IDLE;
            if (synced_q && ram_ready && (win_a || win_b)) begin
                state_d    = win_a ? ST_BUSY_A : ST_BUSY_B;
                mem_addr_d = win_a ? bus.a_addr : bus.b_addr;
                mem_we_d   = win_a ? bus.a_we   : bus.b_we;
                mem_din_d  = win_a ? bus.a_din  : bus.b_din;
                mem_aux_d  = win_a ? bus.a_aux  : bus.b_aux;
`ifdef FAIR_ARB_EN
                rr_last_d  = win_a ? PORT_A : PORT_B;
`endif
            end else begin
                // Idle slot: the controller must not see a stale write.
                mem_we_d = 1'b0;
            end
        end

        // CAPTURE_PHASE lies before LATCH_PHASE, so the access granted in
        // this slot is always completed before the next decision.
        if (phase_q == PW'(CAPTURE_PHASE)) begin
            case (state_q)
                ST_BUSY_A: begin
                    a_ack_d = 1'b1;
                    if (!mem_we_q) a_dout_d = rd_byte;
                end
                ST_BUSY_B: begin
                    b_ack_d = 1'b1;
                    if (!mem_we_q) b_dout_d = rd_byte;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: non-blocking assignments keep every register sampling the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            phase_q    <= '0;
            synced_q   <= 1'b0;
            state_q    <= ST_IDLE;
            mem_addr_q <= '0;
            mem_we_q   <= 1'b0;
            mem_din_q  <= '0;
            mem_aux_q  <= 1'b0;
            a_dout_q   <= '0;
            a_ack_q    <= 1'b0;
            b_dout_q   <= '0;
            b_ack_q    <= 1'b0;
`ifdef FAIR_ARB_EN
            rr_last_q  <= PORT_B;
`endif
        end else begin
            phase_q    <= phase_d;
            synced_q   <= synced_d;
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            mem_we_q   <= mem_we_d;
            mem_din_q  <= mem_din_d;
            mem_aux_q  <= mem_aux_d;
            a_dout_q   <= a_dout_d;
            a_ack_q    <= a_ack_d;
            b_dout_q   <= b_dout_d;
            b_ack_q    <= b_ack_d;
`ifdef FAIR_ARB_EN
            rr_last_q  <= rr_last_d;
`endif
        end
    end

    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_we   = mem_we_q;
    assign bus.mem_din  = mem_din_q;
    assign bus.mem_aux  = mem_aux_q;
    assign bus.a_dout   = a_dout_q;
    assign bus.a_ack    = a_ack_q;
    assign bus.b_dout   = b_dout_q;
    assign bus.b_ack    = b_ack_q;

endmodule

// File: tb/tb_sdram_req_sched.sv
// ----------------------------------------------------------------------------
// tb_sdram_req_sched
//   Directed bench for sdram_req_sched. A bench-side slot counter drives
//   clkref high for one clock in every 14, which locks the scheduler phase
//   to that counter (cnt). Each table row is one memory slot: inputs are set
//   in the phase-13 cycle, then the following 14 cycles are observed.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sdram_req_sched;

    logic clk = 1'b0;
    logic init_n;
    logic clkref;
    logic ram_ready;
    int   cnt;

    int   n_vec = 0;
    int   n_err = 0;

`ifdef FAIR_ARB_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    sdram_req_sched_if bus ();

    sdram_req_sched dut (
        .clk       (clk),
        .init_n    (init_n),
        .clkref    (clkref),
        .ram_ready (ram_ready),
        .bus       (bus)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic        a_req;
        logic [24:0] a_addr;
        logic        a_aux;
        logic        a_we;
        logic [7:0]  a_din;
        logic        b_req;
        logic [24:0] b_addr;
        logic        b_aux;
        logic        b_we;
        logic [7:0]  b_din;
        logic [15:0] mem_dout;
        int          exp_port;   // 0 none, 1 A, 2 B
        logic [7:0]  exp_a_dout;
        logic [7:0]  exp_b_dout;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(
        input logic rdy,
        input logic ar, input logic [24:0] aa, input logic ax, input logic aw, input logic [7:0] ad,
        input logic br, input logic [24:0] ba, input logic bx, input logic bw, input logic [7:0] bd,
        input logic [15:0] md, input int ep, input logic [7:0] ea, input logic [7:0] eb);
        vec_t v;
        v.rdy = rdy;
        v.a_req = ar; v.a_addr = aa; v.a_aux = ax; v.a_we = aw; v.a_din = ad;
        v.b_req = br; v.b_addr = ba; v.b_aux = bx; v.b_we = bw; v.b_din = bd;
        v.mem_dout = md; v.exp_port = ep; v.exp_a_dout = ea; v.exp_b_dout = eb;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: advance the bench slot counter just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cnt    = (cnt == 13) ? 0 : cnt + 1;
        clkref = (cnt == 0);
    endtask

    task automatic run_to(input int p);
        for (int i = 0; i < 14 && cnt != p; i++) tick();
    endtask

    task automatic check_mem(input string tag, input vec_t v);
        if (v.exp_port == 1) begin
            check({tag, "_addr"}, 32'(bus.mem_addr), 32'(v.a_addr));
            check({tag, "_we"},   32'(bus.mem_we),   32'(v.a_we));
            check({tag, "_din"},  32'(bus.mem_din),  32'(v.a_din));
            check({tag, "_aux"},  32'(bus.mem_aux),  32'(v.a_aux));
        end else if (v.exp_port == 2) begin
            check({tag, "_addr"}, 32'(bus.mem_addr), 32'(v.b_addr));
            check({tag, "_we"},   32'(bus.mem_we),   32'(v.b_we));
            check({tag, "_din"},  32'(bus.mem_din),  32'(v.b_din));
            check({tag, "_aux"},  32'(bus.mem_aux),  32'(v.b_aux));
        end else begin
            check({tag, "_we_idle"}, 32'(bus.mem_we), 32'd0);
        end
    endtask

    initial begin
        vec_t v;
        logic [13:0] a_mask, b_mask;
        int elapsed;

        // Rows 4..7: both ports request every slot.
        // Rows 8..10: ram_ready low, A pending; row 11 releases it.
        vecs[0]  = mk(1, 1, 25'h0000123, 0, 0, 8'h00, 0, 25'h0, 0, 0, 8'h00, 16'hBEEF, 1, 8'hEF, 8'h00);
        vecs[1]  = mk(1, 1, 25'h0000123, 1, 0, 8'h00, 0, 25'h0, 0, 0, 8'h00, 16'hBEEF, 1, 8'hBE, 8'h00);
        vecs[2]  = mk(1, 0, 25'h0, 0, 0, 8'h00, 1, 25'h001FFFF, 0, 1, 8'h5A, 16'h1234, 2, 8'hBE, 8'h00);
        vecs[3]  = mk(1, 0, 25'h0, 0, 0, 8'h00, 1, 25'h000ABCD, 1, 0, 8'h11, 16'h7711, 2, 8'hBE, 8'h77);
        vecs[4]  = mk(1, 1, 25'h1000000, 0, 0, 8'hA1, 1, 25'h0000042, 1, 0, 8'hB2, 16'h1122,
                      1, 8'h22, 8'h77);
        vecs[5]  = mk(1, 1, 25'h1000000, 0, 0, 8'hA1, 1, 25'h0000042, 1, 0, 8'hB2, 16'h3344,
                      FAIR ? 2 : 1, FAIR ? 8'h22 : 8'h44, FAIR ? 8'h33 : 8'h77);
        vecs[6]  = mk(1, 1, 25'h1000000, 0, 0, 8'hA1, 1, 25'h0000042, 1, 0, 8'hB2, 16'h5566,
                      1, 8'h66, FAIR ? 8'h33 : 8'h77);
        vecs[7]  = mk(1, 1, 25'h1000000, 0, 0, 8'hA1, 1, 25'h0000042, 1, 0, 8'hB2, 16'h7788,
                      FAIR ? 2 : 1, FAIR ? 8'h66 : 8'h88, 8'h77);
        vecs[8]  = mk(0, 1, 25'h0000777, 0, 0, 8'h00, 0, 25'h0, 0, 0, 8'h00, 16'h9999,
                      0, FAIR ? 8'h66 : 8'h88, 8'h77);
        vecs[9]  = vecs[8];
        vecs[10] = vecs[8];
        vecs[11] = mk(1, 1, 25'h0000777, 0, 0, 8'h00, 0, 25'h0, 0, 0, 8'h00, 16'hA55A, 1, 8'h5A, 8'h77);
        vecs[12] = mk(1, 1, 25'h1ABCDEF, 1, 1, 8'hC3, 0, 25'h0, 0, 0, 8'h00, 16'h6655, 1, 8'h5A, 8'h77);
        vecs[13] = mk(1, 0, 25'h0, 0, 0, 8'h00, 0, 25'h0, 0, 0, 8'h00, 16'h0F0F, 0, 8'h5A, 8'h77);

        // Reset
        cnt = 0; clkref = 1'b1; init_n = 1'b0; ram_ready = 1'b1;
        bus.a_req = 0; bus.a_addr = '0; bus.a_aux = 0; bus.a_we = 0; bus.a_din = '0;
        bus.b_req = 0; bus.b_addr = '0; bus.b_aux = 0; bus.b_we = 0; bus.b_din = '0;
        bus.mem_dout = '0;
        tick(); tick(); tick();
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_mem_we",   32'(bus.mem_we),   32'd0);
        check("rst_a_ack",    32'(bus.a_ack),    32'd0);
        check("rst_b_ack",    32'(bus.b_ack),    32'd0);
        check("rst_a_dout",   32'(bus.a_dout),   32'd0);
        init_n = 1'b1;
        for (int i = 0; i < 30; i++) tick();
        run_to(13);

        // Table-driven slots
        for (int n = 0; n < 14; n++) begin
            v = vecs[n];
            ram_ready   = v.rdy;
            bus.a_req   = v.a_req; bus.a_addr = v.a_addr; bus.a_aux = v.a_aux;
            bus.a_we    = v.a_we;  bus.a_din  = v.a_din;
            bus.b_req   = v.b_req; bus.b_addr = v.b_addr; bus.b_aux = v.b_aux;
            bus.b_we    = v.b_we;  bus.b_din  = v.b_din;
            bus.mem_dout = ~v.mem_dout;
            a_mask = '0; b_mask = '0;
            for (int i = 0; i < 14; i++) begin
                tick();
                bus.mem_dout = (cnt == 5) ? v.mem_dout : ~v.mem_dout;
                a_mask[i] = bus.a_ack;
                b_mask[i] = bus.b_ack;
                if (i == 0)  check_mem($sformatf("v%0d_ph0", n), v);
                if (i == 1)  check_mem($sformatf("v%0d_ph1", n), v);
                if (i == 13) check_mem($sformatf("v%0d_ph13", n), v);
                if (i == 6) begin
                    check($sformatf("v%0d_a_dout", n), 32'(bus.a_dout), 32'(v.exp_a_dout));
                    check($sformatf("v%0d_b_dout", n), 32'(bus.b_dout), 32'(v.exp_b_dout));
                end
                if (i == 7) begin
                    if (v.exp_port == 1) bus.a_req = 1'b0;
                    if (v.exp_port == 2) bus.b_req = 1'b0;
                end
            end
            check($sformatf("v%0d_a_ack_pattern", n), 32'(a_mask),
                  (v.exp_port == 1) ? 32'h40 : 32'h0);
            check($sformatf("v%0d_b_ack_pattern", n), 32'(b_mask),
                  (v.exp_port == 2) ? 32'h40 : 32'h0);
        end

        // Reset in the middle of a BUSY_A slot (now at phase 13)
        ram_ready = 1'b1;
        bus.a_req = 1'b1; bus.a_addr = 25'h0000055; bus.a_aux = 1'b0; bus.a_we = 1'b0;
        bus.b_req = 1'b0;
        bus.mem_dout = 16'h00F0;
        tick();
        check("mid_grant_addr", 32'(bus.mem_addr), 32'h55);
        run_to(3);
        init_n = 1'b0;
        #1;
        check("mid_rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("mid_rst_a_dout",   32'(bus.a_dout),   32'd0);
        check("mid_rst_a_ack",    32'(bus.a_ack),    32'd0);
        tick(); tick();
        init_n = 1'b1;
        // Released in phase 5: the phase waits for clkref, the next wrap only
        // re-acquires sync, the wrap after that grants, and the ack appears in
        // phase 6 of the following slot: 9 + 14 + 14 + 6 = 43 clocks.
        elapsed = 0;
        while (elapsed < 80 && !bus.a_ack) begin
            tick();
            elapsed++;
        end
        check("mid_rst_ack_delay", 32'(elapsed), 32'd43);
        check("mid_rst_a_dout_after", 32'(bus.a_dout), 32'hF0);
        bus.a_req = 1'b0;
        tick();
        check("mid_rst_ack_single", 32'(bus.a_ack), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
